// File: rtl/runner_scroll_engine_if.sv
// Obstacle-column handshake between the obstacle source and the scroll engine.
interface runner_scroll_engine_if #(
  parameter int HW = 2
);
  logic [HW-1:0] obs_height;
  logic          obs_valid;
  logic          obs_ready;

  modport master (output obs_height, output obs_valid, input obs_ready);
  modport slave  (input obs_height, input obs_valid, output obs_ready);
endinterface

// File: rtl/runner_scroll_engine.sv
// Side-scroller engine: height-field scroll, runner jump physics, collision,
// score and game-over, stepped by a programmable clock divisor.
module runner_scroll_engine #(
  parameter int COLS    = 80,
  parameter int HW      = 2,
  parameter int RATE_W  = 28,
  parameter int SCORE_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 run,
  input  logic                 jump,
  input  logic [RATE_W-1:0]    rate,
  runner_scroll_engine_if.slave obs,
  output logic [COLS*HW-1:0]   field,
  output logic [HW-1:0]        runner_h,
  output logic                 step,
  output logic                 collide,
  output logic                 game_over,
  output logic [SCORE_W-1:0]   score
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  localparam logic [HW-1:0] MAXH = '1;
  localparam logic [HW-1:0] ONE  = HW'(1);

  state_t               r_state, w_state_nxt;
  logic [RATE_W-1:0]    r_count;
  logic [COLS*HW-1:0]   r_field;
  logic [HW-1:0]        r_runner_h;
  logic                 r_up;
  logic                 r_jump_lat;
  logic                 r_jump_d;
  logic [SCORE_W-1:0]   r_score;
  logic                 r_step;
  logic                 r_collide;
  logic                 r_game_over;

  logic                 w_fire;
  logic                 w_hit;
  logic                 w_jump_rise;
  logic [HW-1:0]        w_new_col;
  logic [COLS*HW-1:0]   w_new_field;
  logic [HW-1:0]        w_new_h;
  logic                 w_new_up;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    // start outranks a step, so a fire cycle never coincides with a restart
    w_fire      = (r_state == S_RUN) && run && !start && (r_count == '0);
    w_jump_rise = jump && !r_jump_d;
    w_new_col   = obs.obs_valid ? obs.obs_height : '0;
    w_new_field = {w_new_col, r_field[COLS*HW-1:HW]};

    w_new_h  = r_runner_h;
    w_new_up = r_up;
    if (r_runner_h == '0) begin
      if (r_jump_lat) begin
        w_new_h  = ONE;
        w_new_up = 1'b1;
      end
    end else if (r_up) begin
      if (r_runner_h == MAXH) begin
        w_new_up = 1'b0;
        w_new_h  = MAXH - ONE;
      end else begin
        w_new_h  = r_runner_h + ONE;
      end
    end else begin
      w_new_h = r_runner_h - ONE;
    end

    w_hit = (w_new_field[HW-1:0] != '0) && (w_new_h < w_new_field[HW-1:0]);

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN:  if (start) w_state_nxt = S_RUN;
              else if (w_fire && w_hit) w_state_nxt = S_OVER;
      S_OVER: if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count     <= '0;
      r_field     <= '0;
      r_runner_h  <= '0;
      r_up        <= 1'b0;
      r_jump_lat  <= 1'b0;
      r_jump_d    <= 1'b0;
      r_score     <= '0;
      r_step      <= 1'b0;
      r_collide   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_jump_d  <= jump;
      r_step    <= w_fire;
      r_collide <= w_fire && w_hit;
      if (start) begin
        r_field     <= '0;
        r_runner_h  <= '0;
        r_up        <= 1'b0;
        r_score     <= '0;
        r_jump_lat  <= 1'b0;
        r_count     <= rate;
        r_game_over <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (run) r_count <= (r_count == '0) ? rate : r_count - RATE_W'(1);
        if (w_fire) begin
          // every step consumes the latch, so presses while airborne are lost
          r_jump_lat <= 1'b0;
          if (w_hit) begin
            r_game_over <= 1'b1;
          end else begin
            r_field    <= w_new_field;
            r_runner_h <= w_new_h;
            r_up       <= w_new_up;
            if (r_score != '1) r_score <= r_score + SCORE_W'(1);
          end
        end else if (w_jump_rise) begin
          r_jump_lat <= 1'b1;
        end
      end
    end
  end

  assign obs.obs_ready = w_fire;
  assign field         = r_field;
  assign runner_h      = r_runner_h;
  assign step          = r_step;
  assign collide       = r_collide;
  assign game_over     = r_game_over;
  assign score         = r_score;

endmodule

// File: tb/tb_runner_scroll_engine.sv
// Directed bench for runner_scroll_engine with COLS=8, HW=2, rate=3.
module tb_runner_scroll_engine;
  localparam int COLS = 8;
  localparam int HW   = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start, run, jump;
  logic [27:0]       rate;
  logic [COLS*HW-1:0] field;
  logic [HW-1:0]     runner_h;
  logic              step, collide, game_over;
  logic [15:0]       score;
  int                total = 0;
  int                bad   = 0;

  runner_scroll_engine_if #(.HW(HW)) obs_if ();

  runner_scroll_engine #(.COLS(COLS), .HW(HW), .RATE_W(28), .SCORE_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .run(run), .jump(jump),
    .rate(rate), .obs(obs_if), .field(field), .runner_h(runner_h),
    .step(step), .collide(collide), .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One full step period; the step lands on the 4th tick.
  task automatic run_step(input logic [HW-1:0] h, input logic v, input logic press);
    obs_if.obs_height = h;
    obs_if.obs_valid  = v;
    jump = press;
    tick();
    jump = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; run = 1'b1; jump = 1'b0; rate = 28'd3;
    obs_if.obs_height = 2'd3; obs_if.obs_valid = 1'b1;
    tick(); tick();
    total++; if (field !== 16'h0) begin bad++; $display("FAIL reset_field got=%h want=0", field); end
    total++; if (score !== 16'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", score); end
    total++; if ({step, collide, game_over} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {step, collide, game_over}); end
    total++; if (obs_if.obs_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", obs_if.obs_ready); end
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (step !== 1'b0 || obs_if.obs_ready !== 1'b0) begin bad++; $display("FAIL idle_nostep step=%b ready=%b want 0/0", step, obs_if.obs_ready); end
    end
  endtask

  task automatic test_free_run();
    obs_if.obs_valid = 1'b0; run = 1'b1;
    do_start();
    for (int k = 1; k <= 3; k++) begin
      for (int i = 1; i <= 4; i++) begin
        tick();
        total++; if (obs_if.obs_ready !== (i == 3)) begin bad++; $display("FAIL free_ready k=%0d i=%0d got=%b want=%b", k, i, obs_if.obs_ready, (i == 3)); end
        total++; if (step !== (i == 4)) begin bad++; $display("FAIL free_step k=%0d i=%0d got=%b want=%b", k, i, step, (i == 4)); end
      end
      total++; if (score !== 16'(k)) begin bad++; $display("FAIL free_score got=%0d want=%0d", score, k); end
      total++; if (field !== 16'h0) begin bad++; $display("FAIL free_field got=%h want=0", field); end
    end
  endtask

  task automatic test_pause();
    run = 1'b1; obs_if.obs_valid = 1'b0;
    do_start();
    tick(); tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (step !== 1'b0 || obs_if.obs_ready !== 1'b0) begin bad++; $display("FAIL pause_hold i=%0d step=%b ready=%b want 0/0", i, step, obs_if.obs_ready); end
    end
    run = 1'b1;
    tick();
    total++; if (obs_if.obs_ready !== 1'b1 || step !== 1'b0) begin bad++; $display("FAIL pause_resume1 ready=%b step=%b want 1/0", obs_if.obs_ready, step); end
    tick();
    total++; if (step !== 1'b1 || score !== 16'd1) begin bad++; $display("FAIL pause_resume2 step=%b score=%0d want 1/1", step, score); end
  endtask

  task automatic test_collision();
    logic [HW-1:0] seq [8];
    seq = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    run = 1'b1;
    do_start();
    total++; if (field !== 16'h0 || score !== 16'd0) begin bad++; $display("FAIL restart_in_run field=%h score=%0d want 0/0", field, score); end
    for (int k = 1; k <= 7; k++) begin
      run_step(seq[k-1], 1'b1, 1'b0);
      total++; if (step !== 1'b1 || collide !== 1'b0 || score !== 16'(k)) begin bad++; $display("FAIL coll_step k=%0d step=%b collide=%b score=%0d want 1/0/%0d", k, step, collide, score, k); end
      total++; if (field !== (16'd2 << (2 * (8 - k)))) begin bad++; $display("FAIL coll_field k=%0d got=%h want=%h", k, field, 16'd2 << (2 * (8 - k))); end
    end
    run_step(seq[7], 1'b1, 1'b0);
    total++; if (collide !== 1'b1 || game_over !== 1'b1) begin bad++; $display("FAIL coll_hit collide=%b over=%b want 1/1", collide, game_over); end
    total++; if (score !== 16'd7 || field !== 16'h0008) begin bad++; $display("FAIL coll_freeze score=%0d field=%h want 7/0008", score, field); end
    obs_if.obs_height = 2'd3; jump = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (step !== 1'b0 || collide !== 1'b0 || game_over !== 1'b1 || obs_if.obs_ready !== 1'b0) begin bad++; $display("FAIL over_idle i=%0d step=%b collide=%b over=%b ready=%b want 0/0/1/0", i, step, collide, game_over, obs_if.obs_ready); end
    end
    jump = 1'b0;
    total++; if (score !== 16'd7 || field !== 16'h0008 || runner_h !== 2'd0) begin bad++; $display("FAIL over_frozen score=%0d field=%h h=%0d want 7/0008/0", score, field, runner_h); end
    obs_if.obs_valid = 1'b0;
    do_start();
    total++; if (field !== 16'h0 || score !== 16'd0 || game_over !== 1'b0) begin bad++; $display("FAIL over_restart field=%h score=%0d over=%b want 0/0/0", field, score, game_over); end
    run_step(2'd0, 1'b0, 1'b0);
    total++; if (step !== 1'b1 || score !== 16'd1) begin bad++; $display("FAIL over_restart_step step=%b score=%0d want 1/1", step, score); end
  endtask

  task automatic test_jump();
    logic [HW-1:0] exp_h [7];
    exp_h = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    run = 1'b1; obs_if.obs_valid = 1'b0;
    do_start();
    for (int k = 1; k <= 7; k++) begin
      run_step(2'd0, 1'b0, (k == 1) || (k == 4));
      total++; if (runner_h !== exp_h[k-1] || step !== 1'b1) begin bad++; $display("FAIL jump_h k=%0d got=%0d want=%0d step=%b", k, runner_h, exp_h[k-1], step); end
    end
  endtask

  task automatic test_jump_over();
    run = 1'b1;
    do_start();
    for (int k = 1; k <= 9; k++) begin
      run_step((k == 1) ? 2'd2 : 2'd0, 1'b1, (k == 5));
      total++; if (collide !== 1'b0 || game_over !== 1'b0 || score !== 16'(k)) begin bad++; $display("FAIL jover_step k=%0d collide=%b over=%b score=%0d want 0/0/%0d", k, collide, game_over, score, k); end
    end
    total++; if (runner_h !== 2'd1 || field !== 16'h0) begin bad++; $display("FAIL jover_after h=%0d field=%h want 1/0", runner_h, field); end
  endtask

  task automatic test_jump_over_peak();
    run = 1'b1;
    do_start();
    for (int k = 1; k <= 8; k++) begin
      run_step((k == 1) ? 2'd2 : 2'd0, 1'b1, (k == 5));
      if (k == 7) begin
        total++; if (runner_h !== 2'd3) begin bad++; $display("FAIL jpeak_h7 got=%0d want=3", runner_h); end
      end
    end
    total++; if (runner_h !== 2'd2 || collide !== 1'b0 || score !== 16'd8 || field !== 16'h0002) begin bad++; $display("FAIL jpeak_s8 h=%0d collide=%b score=%0d field=%h want 2/0/8/0002", runner_h, collide, score, field); end
  endtask

  task automatic test_async_reset();
    run = 1'b1;
    do_start();
    run_step(2'd3, 1'b1, 1'b1);
    total++; if (field !== 16'hC000 || runner_h !== 2'd1 || score !== 16'd1) begin bad++; $display("FAIL ar_pre field=%h h=%0d score=%0d want C000/1/1", field, runner_h, score); end
    tick();
    #2 resetn = 1'b0;
    #1;
    total++; if (field !== 16'h0 || runner_h !== 2'd0 || score !== 16'd0) begin bad++; $display("FAIL ar_clear field=%h h=%0d score=%0d want 0/0/0", field, runner_h, score); end
    total++; if ({step, collide, game_over, obs_if.obs_ready} !== 4'b0000) begin bad++; $display("FAIL ar_flags got=%b want=0000", {step, collide, game_over, obs_if.obs_ready}); end
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (step !== 1'b0) begin bad++; $display("FAIL ar_idle i=%0d step=%b want=0", i, step); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pause();
    test_collision();
    test_jump();
    test_jump_over();
    test_jump_over_peak();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
